// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: maps iterator coordinates to framebuffer addresses,
// looks colour indices up in a writable palette, keeps hs/vs/de aligned with
// the RGB pipeline and manages the front/back bank handshake with the renderer.
module framebuffer_scanout #(
  parameter int HOR_ACTIVE_PIXELS = 480,
  parameter int VER_ACTIVE_PIXELS = 272,
  parameter int HOR_SYNC_POLARITY = 0,
  parameter int VER_SYNC_POLARITY = 0,
  parameter int SCALE_SHIFT       = 1,
  parameter int INDEX_WIDTH       = 4,
  parameter int MEM_LATENCY       = 2,
  localparam int FB_W       = HOR_ACTIVE_PIXELS >> SCALE_SHIFT,
  localparam int FB_H       = VER_ACTIVE_PIXELS >> SCALE_SHIFT,
  localparam int FB_SIZE    = FB_W * FB_H,
  localparam int ADDR_WIDTH = $clog2(2 * FB_SIZE),
  localparam int X_W        = $clog2(HOR_ACTIVE_PIXELS),
  localparam int Y_W        = $clog2(VER_ACTIVE_PIXELS)
) (
  input  logic                   clk_rgb,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [X_W-1:0]         x,
  input  logic [Y_W-1:0]         y,
  input  logic                   hs_in,
  input  logic                   vs_in,
  input  logic                   de_in,
  input  logic                   swap,
  input  logic                   frame_done,
  output logic                   back_ready,
  output logic                   back_bank,
  output logic                   swapped,
  output logic                   rd_en,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic [INDEX_WIDTH-1:0] rd_data,
  input  logic                   pal_we,
  input  logic [INDEX_WIDTH-1:0] pal_addr,
  input  logic [23:0]            pal_data,
  output logic [7:0]             r,
  output logic [7:0]             g,
  output logic [7:0]             b,
  output logic                   hs,
  output logic                   vs,
  output logic                   de
);

  // Total pipeline depth: address register, RAM latency, palette register.
  localparam int L      = MEM_LATENCY + 2;
  localparam int PAL_N  = 1 << INDEX_WIDTH;
  localparam logic HS_IDLE = (HOR_SYNC_POLARITY == 0) ? 1'b1 : 1'b0;
  localparam logic VS_IDLE = (VER_SYNC_POLARITY == 0) ? 1'b1 : 1'b0;

  logic                  front_bank_r;
  logic                  pending_r;
  logic                  swapped_r;
  logic                  fd_accept_s;
  logic                  flip_s;
  logic [ADDR_WIDTH-1:0] addr_next_s;
  logic [ADDR_WIDTH-1:0] rd_addr_r;
  logic [L-1:0]          hs_dly_r;
  logic [L-1:0]          vs_dly_r;
  logic [L-1:0]          de_dly_r;
  logic [23:0]           rgb_r;
  logic [23:0]           pal_r [PAL_N];

  // Bank handshake decode: accept frame_done only when the back bank is free;
  // flip at a frame event if a finished frame is waiting or arrives now.
  always_comb begin
    fd_accept_s = frame_done & ~pending_r;
    flip_s      = swap & ce & (pending_r | fd_accept_s);
  end

  // Framebuffer address for the current pixel, using the pre-flip front bank.
  always_comb begin
    addr_next_s = (front_bank_r ? ADDR_WIDTH'(FB_SIZE) : {ADDR_WIDTH{1'b0}})
                + ADDR_WIDTH'(32'(y >> SCALE_SHIFT) * FB_W)
                + ADDR_WIDTH'(x >> SCALE_SHIFT);
  end

  // Front bank, pending request and the one-cycle swapped pulse.
  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      front_bank_r <= 1'b0;
      pending_r    <= 1'b0;
      swapped_r    <= 1'b0;
    end else begin
      swapped_r <= flip_s;
      if (flip_s) begin
        front_bank_r <= ~front_bank_r;
        pending_r    <= 1'b0;
      end else if (fd_accept_s) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  // Address stage: load on active pixels, hold during blanking.
  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      rd_addr_r <= {ADDR_WIDTH{1'b0}};
    end else if (ce && de_in) begin
      rd_addr_r <= addr_next_s;
    end else begin
      rd_addr_r <= rd_addr_r;
    end
  end

  // Sync/data-enable delay line, L ce-cycles deep, idles at inactive levels.
  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      hs_dly_r <= {L{HS_IDLE}};
      vs_dly_r <= {L{VS_IDLE}};
      de_dly_r <= {L{1'b0}};
    end else if (ce) begin
      hs_dly_r <= {hs_dly_r[L-2:0], hs_in};
      vs_dly_r <= {vs_dly_r[L-2:0], vs_in};
      de_dly_r <= {de_dly_r[L-2:0], de_in};
    end else begin
      hs_dly_r <= hs_dly_r;
      vs_dly_r <= vs_dly_r;
      de_dly_r <= de_dly_r;
    end
  end

  // Palette storage: written on any edge, independent of the pixel enable.
  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      for (int i = 0; i < PAL_N; i++) begin
        pal_r[i] <= 24'h000000;
      end
    end else if (pal_we) begin
      pal_r[pal_addr] <= pal_data;
    end else begin
      pal_r[pal_addr] <= pal_r[pal_addr];
    end
  end

  // Palette lookup register; blanks the colour when the aligned de is low.
  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      rgb_r <= 24'h000000;
    end else if (ce) begin
      rgb_r <= de_dly_r[L-2] ? pal_r[rd_data] : 24'h000000;
    end else begin
      rgb_r <= rgb_r;
    end
  end

  assign rd_en      = ce;
  assign rd_addr    = rd_addr_r;
  assign back_ready = ~pending_r;
  assign back_bank  = ~front_bank_r;
  assign swapped    = swapped_r;
  assign r          = rgb_r[23:16];
  assign g          = rgb_r[15:8];
  assign b          = rgb_r[7:0];
  assign hs         = hs_dly_r[L-1];
  assign vs         = vs_dly_r[L-1];
  assign de         = de_dly_r[L-1];

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Scoreboard bench for framebuffer_scanout: the driver computes expectations
// from a behavioural model and queues them; a monitor compares every cycle.
module tb_framebuffer_scanout;

  localparam int FB_W    = 240;
  localparam int FB_SIZE = 32640;
  localparam int L       = 4;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
  } pix_t;

  typedef struct packed {
    logic        ce;
    logic [15:0] addr;
    logic        br;
    logic        bb;
    logic        sw;
  } cyc_t;

  localparam pix_t RST_PIX = {1'b1, 1'b1, 1'b0, 24'h000000};

  logic        clk_rgb = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic [8:0]  x = 9'd0;
  logic [8:0]  y = 9'd0;
  logic        hs_in = 1'b1, vs_in = 1'b1, de_in = 1'b0;
  logic        swap = 1'b0, frame_done = 1'b0;
  logic        back_ready, back_bank, swapped, rd_en;
  logic [15:0] rd_addr;
  logic [3:0]  rd_data;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_addr = 4'd0;
  logic [23:0] pal_data = 24'd0;
  logic [7:0]  r, g, b;
  logic        hs, vs, de;

  framebuffer_scanout dut (
    .clk_rgb(clk_rgb), .rst(rst), .ce(ce), .x(x), .y(y),
    .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in), .swap(swap),
    .frame_done(frame_done), .back_ready(back_ready), .back_bank(back_bank),
    .swapped(swapped), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .de(de)
  );

  always #5 clk_rgb = ~clk_rgb;

  // External RAM model: returns addr[3:0] two rd_en-qualified cycles later.
  logic [3:0] ram_p0 = 4'd0, ram_p1 = 4'd0;
  always @(posedge clk_rgb) begin
    if (rd_en) begin
      ram_p0 <= rd_addr[3:0];
      ram_p1 <= ram_p0;
    end
  end
  assign rd_data = ram_p1;

  pix_t        pipe_q[$];
  cyc_t        cyc_q[$];
  logic [23:0] pal_m [16];
  logic        fb_m = 1'b0, pend_m = 1'b0;
  logic [15:0] addr_m = 16'd0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one sample per cycle, #1 after the rising edge.
  initial begin
    pix_t cur;
    cyc_t c;
    cur = RST_PIX;
    forever begin
      @(posedge clk_rgb);
      #1;
      if (rst) begin
        cur = RST_PIX;
      end else if (cyc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sync no expectation queued t=%0t", $time);
      end else begin
        c = cyc_q.pop_front();
        if (c.ce) begin
          if (pipe_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pipe_sync no pixel expectation t=%0t", $time);
          end else begin
            cur = pipe_q.pop_front();
          end
        end
        chk("rd_addr", 32'(rd_addr), 32'(c.addr));
        chk("back_ready", 32'(back_ready), 32'(c.br));
        chk("back_bank", 32'(back_bank), 32'(c.bb));
        chk("swapped", 32'(swapped), 32'(c.sw));
        chk("hs", 32'(hs), 32'(cur.hs));
        chk("vs", 32'(vs), 32'(cur.vs));
        chk("de", 32'(de), 32'(cur.de));
        chk("rgb", 32'({r, g, b}), 32'(cur.rgb));
      end
    end
  end

  // Drive one cycle (called at a falling edge) and queue what the spec predicts.
  task automatic step(input logic c, input logic d, input logic [8:0] xx, input logic [8:0] yy,
                      input logic h, input logic v, input logic s, input logic f,
                      input logic pw, input logic [3:0] pa, input logic [23:0] pd);
    cyc_t e;
    pix_t p;
    logic acc;
    ce = c; de_in = d; x = xx; y = yy; hs_in = h; vs_in = v;
    swap = s; frame_done = f; pal_we = pw; pal_addr = pa; pal_data = pd;
    if (c && d) begin
      addr_m = 16'((fb_m ? FB_SIZE : 0) + int'(yy / 2) * FB_W + int'(xx / 2));
    end
    if (c) begin
      p.hs  = h;
      p.vs  = v;
      p.de  = d;
      p.rgb = d ? pal_m[addr_m[3:0]] : 24'h000000;
      pipe_q.push_back(p);
    end
    if (pw) pal_m[pa] = pd;
    acc  = f && !pend_m;
    e.sw = 1'b0;
    if (s && c && (pend_m || acc)) begin
      fb_m   = ~fb_m;
      pend_m = 1'b0;
      e.sw   = 1'b1;
    end else if (acc) begin
      pend_m = 1'b1;
    end
    e.ce   = c;
    e.addr = addr_m;
    e.br   = ~pend_m;
    e.bb   = ~fb_m;
    cyc_q.push_back(e);
    @(negedge clk_rgb);
  endtask

  task automatic px(input logic c, input logic d, input logic [8:0] xx, input logic [8:0] yy,
                    input logic h, input logic v, input logic s, input logic f);
    step(c, d, xx, yy, h, v, s, f, 1'b0, 4'd0, 24'd0);
  endtask

  task automatic idle(input logic c);
    px(c, 1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic rand_px(input int ce_div);
    logic c;
    c = ($urandom_range(0, ce_div - 1) == 0);
    px(c, ($urandom_range(0, 3) != 0), 9'($urandom_range(0, 479)), 9'($urandom_range(0, 271)),
       1'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0));
  endtask

  // Reset with a frame event and frame_done present; reset must win.
  task automatic do_reset();
    rst = 1'b1; ce = 1'b1; swap = 1'b1; frame_done = 1'b1; de_in = 1'b1;
    @(negedge clk_rgb);
    rst = 1'b0; ce = 1'b0; swap = 1'b0; frame_done = 1'b0; de_in = 1'b0;
    hs_in = 1'b1; vs_in = 1'b1;
    pipe_q.delete();
    repeat (L - 1) pipe_q.push_back(RST_PIX);
    fb_m = 1'b0; pend_m = 1'b0; addr_m = 16'd0;
    for (int i = 0; i < 16; i++) pal_m[i] = 24'h000000;
  endtask

  initial begin
    @(negedge clk_rgb);
    do_reset();
    repeat (10) idle(1'b1);

    // Palette i*0x111111, written while ce is low.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'(i), 24'(i * 24'h111111));

    // Directed addresses and bank handshake cases.
    px(1'b1, 1'b1, 9'd5, 9'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    px(1'b1, 1'b1, 9'd479, 9'd271, 1'b1, 1'b1, 1'b0, 1'b0);
    px(1'b1, 1'b1, 9'd6, 9'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (5) idle(1'b1);
    px(1'b1, 1'b1, 9'd479, 9'd271, 1'b0, 1'b0, 1'b1, 1'b0);
    px(1'b1, 1'b1, 9'd5, 9'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    px(1'b1, 1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    px(1'b1, 1'b1, 9'd5, 9'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    px(1'b1, 1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    px(1'b1, 1'b1, 9'd7, 9'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3) idle(1'b1);
    px(1'b1, 1'b1, 9'd8, 9'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    px(1'b0, 1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    px(1'b1, 1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    px(1'b1, 1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (4) idle(1'b1);

    // Randomized streams: ce every cycle, then ce one cycle in three.
    repeat (300) rand_px(1);
    repeat (300) rand_px(3);

    // Drain, rewrite the palette with random colours under random ce, stream again.
    repeat (L) idle(1'b1);
    for (int i = 0; i < 16; i++) step(1'($urandom), 1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'(i), 24'($urandom));
    repeat (200) rand_px(2);

    // Reset while a request is pending: request lost, palette cleared, no flip.
    px(1'b1, 1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    do_reset();
    repeat (10) px(1'b1, 1'b1, 9'($urandom_range(0, 479)), 9'($urandom_range(0, 271)), 1'b0, 1'b1, 1'b0, 1'b0);
    px(1'b1, 1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2 * L) idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/framebuffer_scanout.md
# framebuffer_scanout

Display-side stage directly downstream of the pixel iterator. Takes the iterator's active-area coordinates, sync, data-enable and end-of-frame `swap` strobe. Fetches colour indices from a double-buffered, integer-downscaled framebuffer in external block RAM and maps them through a writable palette to 24-bit RGB. Delays hs/vs/de to stay pixel-aligned with the RGB, and owns the front/back buffer handshake with the game renderer.

## Interface
- `HOR_ACTIVE_PIXELS`, 480, active width in pixels.
- `VER_ACTIVE_PIXELS`, 272, active height in pixels.
- `HOR_SYNC_POLARITY`, 0, active level of hs.
- `VER_SYNC_POLARITY`, 0, active level of vs.
- `SCALE_SHIFT`, 1, framebuffer is 2^S times smaller per axis. Derived values: FB_W = HOR_ACTIVE_PIXELS>>S, FB_H = VER_ACTIVE_PIXELS>>S, FB_SIZE = FB_W*FB_H.
- `INDEX_WIDTH`, 4, colour index width; palette has 2^INDEX_WIDTH entries.
- `MEM_LATENCY`, 2, RAM read latency in rd_en-qualified cycles (≥1).
- `ADDR_WIDTH`, derived: $clog2(2*FB_SIZE).

Ports:
- `clk_rgb` in 1: pixel-domain clock.
- `rst` in 1: reset, synchronous, active-high.
- `ce` in 1: pixel clock enable. Same signal that drives the iterator.
- `x` in $clog2(HOR_ACTIVE_PIXELS): iterator x.
- `y` in $clog2(VER_ACTIVE_PIXELS): iterator y.
- `hs_in`, `vs_in`, `de_in` in 1: iterator sync and data enable.
- `swap` in 1: iterator last-pixel-of-frame strobe. Combinational and not ce-qualified.
- `frame_done` in 1: renderer pulse, back buffer complete.
- `back_ready` out 1: renderer may draw into the back bank.
- `back_bank` out 1: bank index the renderer writes (= ~front_bank).
- `swapped` out 1: one-cycle pulse on a bank flip.
- `rd_en` out 1: RAM read enable (= ce).
- `rd_addr` out ADDR_WIDTH: RAM read address.
- `rd_data` in INDEX_WIDTH: RAM read data.
- `pal_we` in 1: palette write strobe.
- `pal_addr` in INDEX_WIDTH: palette write entry.
- `pal_data` in 24: palette write value, {R,G,B} 8 bits each.
- `r`, `g`, `b` out 8 each: pixel colour.
- `hs`, `vs`, `de` out 1: delayed sync and data enable.

## Operation
- Frame event: `swap && ce`.
- State `front_bank` is reset to 0. State `pending` is reset to 0. `back_ready` = ~pending.
- `frame_done` is accepted only while back_ready=1; it then sets pending. If pending=1, frame_done is ignored and there is no error.
- At a frame event with pending=1, or with a frame_done accepted in the same cycle: front_bank toggles, pending clears, `swapped`=1 for one clk_rgb cycle.
- At a frame event with pending=0 and no accepted frame_done: nothing changes. The same frame repeats.
- Address stage, on a cycle with ce=1 and de_in=1: rd_addr <= front_bank*FB_SIZE + (y>>S)*FB_W + (x>>S). Implementation may use incremental counters instead of a multiplier. Value must be identical.
- Address stage with de_in=0: rd_addr holds its value.
- The address stage uses the front_bank value before any toggle in the same cycle.
- Palette: registered lookup of rd_data gives {r,g,b}. Output is forced to 0 when the delayed de is 0.
- Palette writes happen on any clk_rgb edge with pal_we=1, independent of ce. A lookup of the entry being written in the same cycle returns the old value.

## Timing
- All pipeline registers and the hs/vs/de delay line advance only when ce=1. Otherwise they hold.
- Latency from iterator inputs to r/g/b/hs/vs/de: L = MEM_LATENCY + 2 ce-cycles. The stages are: address register, RAM (MEM_LATENCY), palette register.
- hs/vs/de delay line is exactly L ce-cycles deep.
- Reset values:
  - rd_addr=0; r=g=b=0; de=0.
  - hs=~HOR_SYNC_POLARITY; vs=~VER_SYNC_POLARITY.
  - All delay-line stages are set to these inactive levels.
  - swapped=0; back_ready=1; back_bank=1; palette entries all 0.
- `swapped` and the bank flip occur on the edge that samples the frame event.
- The first pixel of the next frame reads the new bank.
- rst asserted mid-frame returns to the reset state on the next edge. Any pending request is lost.

## Test plan
- Reset, then 10 idle cycles → hs=vs=1 (polarity 0), de=0, rgb=0, back_ready=1, back_bank=1, swapped=0.
- Default params, front_bank=0, x=5, y=3, de_in=1, ce=1 → rd_addr=242. After a flip, same x/y → rd_addr=32882. Also check x=479, y=271 → rd_addr=32639.
- Model RAM returning addr[3:0], pal[i]=i*0x111111, ce every cycle → rgb for each pixel appears exactly 4 cycles after its x/y. hs/vs/de are shifted by the same 4 cycles. rgb=0 wherever delayed de=0.
- ce high one cycle in three → all latencies measured in ce-cycles; no output changes on ce=0 cycles.
- Three cases:
  - frame_done mid-frame → back_ready=0 until the frame event, then swapped pulses and back_bank flips.
  - frame_done in the same cycle as the frame event → immediate flip.
  - Frame event with no frame_done → no flip.
- Second frame_done while pending → ignored, single flip. Reset asserted while pending → pending cleared, front_bank=0, no swapped pulse.
